// File: rtl/sap_pkg.sv
// -----------------------------------------------------------------------------
// sap_pkg
// Shared SAP definitions: bus and RAM address widths, and the program loader's
// state encoding.
// -----------------------------------------------------------------------------
package sap_pkg;

  localparam int BUS_W      = 8;
  localparam int RAM_ADDR_W = 4;

  // Program loader sequencer states. VERIFY is only reachable when the
  // readback feature is built in.
  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_WAIT   = 3'd1,
    LD_ADDR   = 3'd2,
    LD_DATA   = 3'd3,
    LD_VERIFY = 3'd4,
    LD_NEXT   = 3'd5,
    LD_DONE   = 3'd6
  } loader_state_t;

  // The loader owns the bus and stalls the core in every state except IDLE.
  function automatic logic loader_active(input loader_state_t st);
    return (st != LD_IDLE);
  endfunction

endpackage

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Bus-mastering sequencer that copies a DEPTH-byte program image from a
// valid/ready byte stream into RAM over the shared bus before the CPU runs.
// For each byte it puts the address on the bus with a mar_load strobe, then
// the data byte with a ram_write strobe. The core is held off the bus
// (cpu_hold) for the whole run.
//
// Build option: define LOAD_VERIFY_EN to add a VERIFY state after each write
// that reads the byte back (ram_read) and raises a sticky verify_err on a
// mismatch. Without it ram_read and verify_err are tied low and bus_in is
// unused.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             begins a run when sampled high in IDLE
//   in_valid/in_data  byte stream input; in_ready high only in WAIT
//   bus_out/bus_oe    value driven onto the shared bus and its enable
//   bus_in            bus readback (verify only)
//   mar_load          MAR load strobe
//   ram_write         RAM write strobe
//   ram_read          RAM read strobe (verify only)
//   cpu_hold, busy    high for the whole run (every state but IDLE)
//   done              one-cycle pulse at the end of the run
//   load_addr         address of the byte being handled
//   verify_err        sticky readback mismatch flag
// All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module program_loader
  import sap_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = BUS_W,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_in,
  output logic              mar_load,
  output logic              ram_write,
  output logic              ram_read,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] load_addr,
  output logic              verify_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  loader_state_t     state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] data_r, data_s;
  logic              verify_err_r, verify_err_s;

  // State, address counter, latched byte and sticky error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= LD_IDLE;
      addr_r       <= '0;
      data_r       <= '0;
      verify_err_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      addr_r       <= addr_s;
      data_r       <= data_s;
      verify_err_r <= verify_err_s;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_s      = state_r;
    addr_s       = addr_r;
    data_s       = data_r;
    verify_err_s = verify_err_r;
    case (state_r)
      LD_IDLE: begin
        if (start) begin
          state_s      = LD_WAIT;
          addr_s       = '0;
          verify_err_s = 1'b0;
        end else begin
          state_s = LD_IDLE;
        end
      end
      LD_WAIT: begin
        // in_ready is high throughout WAIT, so in_valid alone completes the handshake
        if (in_valid) begin
          data_s  = in_data;
          state_s = LD_ADDR;
        end else begin
          state_s = LD_WAIT;
        end
      end
      LD_ADDR: state_s = LD_DATA;
`ifdef LOAD_VERIFY_EN
      LD_DATA: state_s = LD_VERIFY;
      LD_VERIFY: begin
        if (bus_in != data_r) begin
          verify_err_s = 1'b1;
        end else begin
          verify_err_s = verify_err_r;
        end
        state_s = LD_NEXT;
      end
`else
      LD_DATA: state_s = LD_NEXT;
      // Unreachable without readback; recover to a safe idle
      LD_VERIFY: begin
        state_s = LD_IDLE;
        addr_s  = '0;
      end
`endif
      LD_NEXT: begin
        // The counter stops at the last address; the run never wraps
        if (addr_r == LAST_ADDR) begin
          state_s = LD_DONE;
        end else begin
          addr_s  = addr_r + ADDR_W'(1);
          state_s = LD_WAIT;
        end
      end
      LD_DONE: begin
        addr_s  = '0;
        state_s = LD_IDLE;
      end
      default: begin
        state_s = LD_IDLE;
        addr_s  = '0;
      end
    endcase
  end

  // Moore output decode from the state register
  always_comb begin
    in_ready  = 1'b0;
    bus_oe    = 1'b0;
    bus_out   = '0;
    mar_load  = 1'b0;
    ram_write = 1'b0;
    ram_read  = 1'b0;
    done      = 1'b0;
    case (state_r)
      LD_IDLE: begin
      end
      LD_WAIT: in_ready = 1'b1;
      LD_ADDR: begin
        bus_oe   = 1'b1;
        bus_out  = DATA_W'(addr_r);
        mar_load = 1'b1;
      end
      LD_DATA: begin
        bus_oe    = 1'b1;
        bus_out   = data_r;
        ram_write = 1'b1;
      end
      LD_VERIFY: begin
`ifdef LOAD_VERIFY_EN
        // Bus released so RAM can drive the readback
        ram_read = 1'b1;
`endif
      end
      LD_NEXT: begin
      end
      LD_DONE: done = 1'b1;
      default: begin
      end
    endcase
  end

  assign busy      = loader_active(state_r);
  assign cpu_hold  = loader_active(state_r);
  assign load_addr = addr_r;

`ifdef LOAD_VERIFY_EN
  assign verify_err = verify_err_r;
`else
  logic unused_bus_in_s;
  assign unused_bus_in_s = ^{bus_in, verify_err_r};
  assign verify_err      = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
// Directed bench for program_loader. A small bus model latches the MAR on
// mar_load, writes a 16-byte RAM on ram_write and answers ram_read readbacks.
// -----------------------------------------------------------------------------
module tb_program_loader;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
`ifdef LOAD_VERIFY_EN
  localparam int CYC_PER_BYTE = 5;
  localparam int VERIFY_ON    = 1;
`else
  localparam int CYC_PER_BYTE = 4;
  localparam int VERIFY_ON    = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic [DATA_W-1:0] bus_in;
  logic              mar_load;
  logic              ram_write;
  logic              ram_read;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] load_addr;
  logic              verify_err;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
    .mar_load(mar_load), .ram_write(ram_write), .ram_read(ram_read),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .load_addr(load_addr),
    .verify_err(verify_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int start_cyc = 0;

  // Bus / RAM model and event counters, sampled on the falling edge
  logic [7:0] mem      [16];
  logic [7:0] addr_log [256];
  logic [3:0] mar_q = 4'd0;
  logic       corrupt3;
  int mar_cnt = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0, done_cyc = 0;
  int wait_err = 0, hold_err = 0, oe_err = 0, fall_err = 0;
  logic prev_done = 1'b0, prev_verr = 1'b0, prev_busy = 1'b0, verr_at_done = 1'b0;

  assign bus_in = ram_read ? ((corrupt3 && mar_q == 4'd3) ? 8'hAA : mem[mar_q]) : 8'h00;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    prev_done <= done;
    prev_verr <= verify_err;
    prev_busy <= busy;
    if (mar_load) begin
      addr_log[mar_cnt[7:0]] <= bus_out;
      mar_q   <= bus_out[3:0];
      mar_cnt <= mar_cnt + 1;
    end
    if (ram_write) begin
      mem[mar_q] <= bus_out;
      wr_cnt     <= wr_cnt + 1;
    end
    if (ram_read) rd_cnt <= rd_cnt + 1;
    if (((mar_load || ram_write) && !bus_oe) || (ram_read && bus_oe)) oe_err <= oe_err + 1;
    if (in_ready && (mar_load || ram_write || ram_read)) wait_err <= wait_err + 1;
    if (prev_done && cpu_hold) hold_err <= hold_err + 1;
    if (done) begin
      done_cnt     <= done_cnt + 1;
      done_cyc     <= cycle;
      verr_at_done <= verify_err;
    end
    if (prev_busy && busy && prev_verr && !verify_err) fall_err <= fall_err + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one load; optional stream gap, stray start pulse, or reset at a byte index
  task automatic run_stream(input logic [7:0] base, input logic [7:0] b3,
                            input int gap_at, input int start_at, input int rst_at);
    int n;
    start = 1'b1;
    @(posedge clk); #1;
    start_cyc = cycle;
    start = 1'b0;
    check("verr_clr_on_start", verify_err, 0);
    check("busy_after_start", busy, 1);
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        for (int g = 0; g < 3; g++) begin
          check("gap_in_ready", in_ready, 1);
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = (i == 3) ? b3 : base + 8'(i);
      if (i == start_at) start = 1'b1;
      n = 0;
      while (!in_ready && n < 40) begin @(negedge clk); n++; end
      if (!in_ready) begin
        check("handshake_timeout", 0, 1);
        in_valid = 1'b0;
        start    = 1'b0;
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_bus_oe", bus_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_mar_load", mar_load, 0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (busy) check("idle_timeout", 0, 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int m0, w0, r0, d0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; corrupt3 = 1'b0;
    #12;
    check("rst_busy0", busy, 0);
    check("rst_hold0", cpu_hold, 0);
    check("rst_in_ready0", in_ready, 0);
    check("rst_bus_oe0", bus_oe, 0);
    check("rst_bus_out0", bus_out, 0);
    check("rst_mar_load0", mar_load, 0);
    check("rst_ram_write0", ram_write, 0);
    check("rst_ram_read0", ram_read, 0);
    check("rst_done0", done, 0);
    check("rst_load_addr0", load_addr, 0);
    check("rst_verify_err0", verify_err, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("idle_no_start", busy, 0);

    // Run A: continuous stream 0x10..0x1F
    m0 = mar_cnt; w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
    run_stream(8'h10, 8'h13, -1, -1, -1);
    wait_idle();
    check("A_mar_count", mar_cnt - m0, 16);
    check("A_write_count", wr_cnt - w0, 16);
    check("A_read_count", rd_cnt - r0, 16 * VERIFY_ON);
    check("A_done_count", done_cnt - d0, 1);
    check("A_cycles", done_cyc - start_cyc, DEPTH * CYC_PER_BYTE);
    for (int i = 0; i < DEPTH; i++) begin
      check("A_addr_seq", addr_log[m0 + i], i);
      check("A_ram", mem[i], 8'h10 + i);
    end
    check("A_verify_err", verify_err, 0);

    // Run B: gap before byte 5, stray start at byte 7, corrupt readback at addr 3
    corrupt3 = 1'b1;
    m0 = mar_cnt; d0 = done_cnt;
    run_stream(8'h20, 8'h55, 5, 7, -1);
    wait_idle();
    corrupt3 = 1'b0;
    check("B_mar_count", mar_cnt - m0, 16);
    check("B_done_count", done_cnt - d0, 1);
    check("B_ram3", mem[3], 8'h55);
    check("B_ram5", mem[5], 8'h25);
    check("B_ram8", mem[8], 8'h28);
    check("B_verr_at_done", verr_at_done, VERIFY_ON);
    check("B_verr_sticky_idle", verify_err, VERIFY_ON);

    // Run C: reset while byte 9 is in the address phase
    m0 = mar_cnt; d0 = done_cnt;
    run_stream(8'h40, 8'h43, -1, -1, 9);
    @(negedge clk);
    check("C_mar_count", mar_cnt - m0, 9);
    check("C_done_count", done_cnt - d0, 0);
    check("C_busy_after_rst", busy, 0);
    check("C_ram8", mem[8], 8'h48);
    check("C_ram9_untouched", mem[9], 8'h29);

    // Run D: fresh run after the reset restarts at address 0
    m0 = mar_cnt; d0 = done_cnt;
    run_stream(8'h60, 8'h63, -1, -1, -1);
    wait_idle();
    check("D_first_addr", addr_log[m0], 0);
    check("D_last_addr", addr_log[m0 + 15], 15);
    check("D_done_count", done_cnt - d0, 1);
    check("D_ram0", mem[0], 8'h60);
    check("D_ram9", mem[9], 8'h69);
    check("D_ram15", mem[15], 8'h6F);

    check("no_strobe_in_wait", wait_err, 0);
    check("hold_low_after_done", hold_err, 0);
    check("bus_oe_ownership", oe_err, 0);
    check("verify_err_sticky", fall_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Bus-mastering sequencer that loads a program image into RAM through the shared 8-bit bus before the CPU runs.
- Holds the CPU core off the bus. Accepts bytes over a valid/ready stream. For each byte it drives the address onto the bus and pulses `mar_load`, then drives the data byte and pulses `ram_write`.
- Sits beside `controller` in `cpu_top`. While `cpu_hold` is high, `cpu_top` forces all core bus enables low and stalls the step counter.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, bus/data width.
- DEPTH, 16, number of bytes loaded per run (must be ≤ 2**ADDR_W, ≥ 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level or pulse; begins a load run when sampled high in IDLE.
- in_valid  in  1  stream byte valid.
- in_data  in  DATA_W  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- bus_out  out  DATA_W  value to drive onto BUS (gated externally by bus_oe).
- bus_oe  out  1  loader owns the bus.
- bus_in  in  DATA_W  BUS readback (used only with LOAD_VERIFY_EN).
- mar_load  out  1  MAR load strobe.
- ram_write  out  1  RAM write strobe.
- ram_read  out  1  RAM read strobe (verify only; else 0).
- cpu_hold  out  1  CPU core held/stalled.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when the run completes.
- load_addr  out  ADDR_W  address of the byte currently being handled.
- verify_err  out  1  sticky readback mismatch flag.

Behaviour:
- Reset (async, rst=1): state IDLE, addr counter=0, data holding register=0, verify_err=0.
  - All strobes, bus_oe, in_ready, busy, cpu_hold, done = 0. bus_out = 0.
- Outputs are Moore-decoded from registered state only. No input-to-output combinational path except none; in_ready depends on state only.
- FSM:
  - IDLE: start=1 → WAIT; addr=0; clear verify_err.
  - WAIT: in_ready=1. On in_valid&&in_ready at a posedge, latch in_data → ADDR.
  - ADDR: bus_oe=1, bus_out={zero-ext, addr}, mar_load=1 for exactly one cycle → DATA.
  - DATA: bus_oe=1, bus_out=latched byte, ram_write=1 for one cycle → VERIFY if enabled, else NEXT.
  - NEXT: if addr==DEPTH-1 → DONE, else addr+1 → WAIT.
  - DONE: done=1 for one cycle; addr → 0 → IDLE.
- busy=1 and cpu_hold=1 in every state except IDLE. cpu_hold is also low in the cycle after DONE.
- Throughput: 4 cycles per byte minimum with in_valid held high (WAIT, ADDR, DATA, NEXT); 5 with verify.
- Total run for DEPTH=16 with a continuous stream: 64 cycles from leaving IDLE to DONE, plus 1 cycle in DONE.
- Stream stall: WAIT persists indefinitely; no strobes are asserted while waiting.
- start while busy: ignored. start held high through DONE: a new run begins on the next IDLE cycle.
- in_valid outside WAIT: ignored (in_ready=0); no byte is consumed.
- Counter never exceeds DEPTH-1. There is no wrap into a second pass within one run.
- Reset mid-run: immediate return to IDLE and bus release. Partially written RAM contents are left as-is.

Optional Feature:
- Macro: LOAD_VERIFY_EN.
- Defined: adds state VERIFY after DATA.
  - In VERIFY: ram_read=1 and bus_oe=0. At the posedge, compare bus_in to the latched byte.
  - On mismatch, set verify_err (sticky until the next start or rst). Then → NEXT.
- Undefined: no VERIFY state; ram_read and verify_err tied 0; bus_in unused.

Decomposition:
- Shared package `sap_pkg`:
  - loader state enum (IDLE, WAIT, ADDR, DATA, VERIFY, NEXT, DONE).
  - BUS_W=8, RAM_ADDR_W=4 constants.
- No sub-module. The counter and FSM live in a single module.

Test Plan:
- Reset then start, stream 0x10..0x1F continuously → 16 mar_load/ram_write pairs; addresses 0..15; bus_out=addr then data; done pulses at cycle 65 after start; cpu_hold drops the cycle after.
- Stream with in_valid low 3 cycles before byte 5 → loader stays in WAIT; no strobes; byte 5 lands at addr 5; in_ready high throughout the gap.
- start pulse during run at byte 7 → ignored; run completes normally with exactly one done pulse.
- Assert rst at byte 9 in ADDR state → same-cycle bus_oe=0, busy=0, cpu_hold=0; next start restarts at addr 0.
- LOAD_VERIFY_EN: model RAM returns 0xAA instead of 0x55 at addr 3 → verify_err=1 after VERIFY of addr 3 and stays 1 to DONE; cleared by next start.
- LOAD_VERIFY_EN undefined: ram_read never asserted; verify_err constant 0; 4 cycles per byte.
